data_ram_responder: RTL and testbench
=====================================

DATA_RAM_RESPONDER -- requirements
Module: data_ram_responder

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, giving the byte-address width of the internal store (2^ADDR_WIDTH bytes).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with the clock and reset ports named as the codebase does.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ram_ce_i  input  1  access request from the CPU memory stage.
REQ-006 ram_w_enable_i  input  1  1 = write, 0 = read.
REQ-007 ram_sel_i  input  4  byte-lane enables; bit i selects data bits [8i+7:8i].
REQ-008 ram_addr_i  input  32  byte address; bits [1:0] ignored (word-aligned).
REQ-009 ram_w_data_i  input  32  write data.
REQ-010 ram_r_data_o  output  32  assembled read data.
REQ-011 ram_busy_o  output  1  stall request to the CPU; high while an access is in progress.
REQ-012 ram_done_o  output  1  one-cycle completion pulse.

Function
REQ-013 The block SHALL hold a byte-wide array of 2^ADDR_WIDTH entries; lane i of a word maps to byte address {ram_addr_i[ADDR_WIDTH-1:2], i[1:0]} (little-endian).
REQ-014 Address bits at or above ADDR_WIDTH SHALL be ignored, so the address space wraps.
REQ-015 The FSM SHALL have states IDLE, BUSY and DONE, and a 2-bit lane counter.
REQ-016 IDLE with ram_ce_i=1: latch address, write data, sel and write enable; clear lane counter to 0 and clear the read assembly register; go to BUSY on the next edge.
REQ-017 IDLE with ram_ce_i=0: remain in IDLE.
REQ-018 BUSY: each cycle process the lane given by the counter, then increment the counter.
- Selected write lane: write that byte into the array.
- Selected read lane: capture that array byte into the matching assembly-register lane.
- Unselected lane: no array change; on a read, that lane reads 0.
REQ-019 BUSY with counter=3: go to DONE after processing the lane; an access always takes exactly 4 BUSY cycles, including sel=0.
REQ-020 DONE: assert ram_done_o for that cycle only, go to IDLE unconditionally, and ignore ram_ce_i.
REQ-021 ram_busy_o SHALL equal (state==IDLE and ram_ce_i) or state==BUSY, combinationally, so the CPU stalls from the request cycle onward.
REQ-022 Latency: a request seen in IDLE at cycle T SHALL give BUSY in cycles T+1..T+4, DONE (busy=0, done=1) in cycle T+5, and IDLE from cycle T+6.
REQ-023 ram_r_data_o SHALL be loaded from the assembly register on entry to DONE after a read and SHALL hold that value until the next read completes.
REQ-024 Writes SHALL NOT change ram_r_data_o.
REQ-025 Inputs SHALL be sampled only in IDLE; input changes during BUSY or DONE SHALL have no effect on the access in flight.
REQ-026 If ram_ce_i remains high after DONE, the block SHALL start a new access in cycle T+6 (re-execution is harmless: reads are repeatable and writes idempotent).
REQ-027 A write followed by a read to the same word SHALL return the written bytes.

Reset
REQ-028 On rst=1, asynchronously, the block SHALL set state to IDLE, the lane counter to 0, ram_r_data_o to 0, ram_busy_o to 0 and ram_done_o to 0.
REQ-029 On reset the latched request registers SHALL be cleared to 0.
REQ-030 The memory array SHALL NOT be reset; its contents persist across rst.
REQ-031 Reset during BUSY SHALL abort the access; lanes written before the reset remain written, later lanes are untouched.
REQ-032 Reset asserted together with ram_ce_i SHALL discard the request.
REQ-033 After rst deasserts, the first edge with ram_ce_i=1 in IDLE SHALL begin a normal access.

Verification
REQ-034 Full-word write then read: write addr 0x10, data 0xDEADBEEF, sel 4'b1111; then read addr 0x10, sel 4'b1111 -> busy high 5 cycles each, done pulse in cycle T+5, r_data 0xDEADBEEF.
REQ-035 Byte-lane write: write 0x11223344 to 0x20 with sel 4'b1111, then write 0xAABBCCDD to 0x20 with sel 4'b0100, then full read -> 0x11BB3344; read with sel 4'b0011 -> 0x00003344.
REQ-036 Wrap and ignore low bits: with ADDR_WIDTH=12, write 0xCAFEF00D to 0x1003; read 0x0000 -> 0xCAFEF00D.
REQ-037 Back-to-back requests: hold ram_ce_i high across two reads of different words -> second access starts in cycle T+6, done pulses at T+5 and T+11, each r_data correct, busy low only during the DONE cycles.
REQ-038 Reset mid-write: write 0xFFFFFFFF over 0x00000000 at 0x40, assert rst when the counter reaches 2 -> outputs 0 immediately; subsequent read of 0x40 returns 0x0000FFFF.
REQ-039 sel=0 access: ce with sel 4'b0000, write 0x12345678 -> 4 BUSY cycles, done pulse, memory unchanged; a read with sel=0 returns 0x00000000.

Source files
------------

// File: rtl/data_ram_responder.sv
// data_ram_responder: byte-organised data memory behind a simple CPU
// memory-stage handshake. Every access spends one cycle per byte lane, so it
// takes a fixed four BUSY cycles followed by one DONE cycle with a done pulse.
module data_ram_responder #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_ce_i,
  input  logic        ram_w_enable_i,
  input  logic [3:0]  ram_sel_i,
  input  logic [31:0] ram_addr_i,
  input  logic [31:0] ram_w_data_i,
  output logic [31:0] ram_r_data_o,
  output logic        ram_busy_o,
  output logic        ram_done_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int WA_W  = ADDR_WIDTH - 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Control and latched-request state
  logic [1:0]      state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [WA_W-1:0] word_addr_q, word_addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      sel_q, sel_d;
  logic            we_q, we_d;

  // Read assembly register and the read data presented to the CPU
  logic [31:0]     asm_q, asm_d;
  logic [31:0]     rdata_q, rdata_d;

  // Byte-wide storage; deliberately never reset so contents survive rst
  logic [7:0]      mem [DEPTH];

  // Per-lane datapath signals
  logic [ADDR_WIDTH-1:0] lane_addr;
  logic [7:0]            lane_rbyte;
  logic [7:0]            lane_wbyte;
  logic                  lane_sel;
  logic                  in_busy;
  logic                  mem_we;
  logic [31:0]           asm_busy;
  logic [7:0]            wbyte_lane [4];

  // Only bits [ADDR_WIDTH-1:2] select a word; the rest of the address is
  // intentionally dropped so the address space wraps.
  logic unused_addr_bits;
  generate
    if (ADDR_WIDTH < 32) begin : g_addr_upper
      assign unused_addr_bits = ^{ram_addr_i[31:ADDR_WIDTH], ram_addr_i[1:0]};
    end else begin : g_addr_full
      assign unused_addr_bits = ^ram_addr_i[1:0];
    end
  endgenerate

  assign in_busy   = (state_q == ST_BUSY);
  assign lane_addr = {word_addr_q, cnt_q};
  assign lane_sel  = sel_q[cnt_q];
  assign mem_we    = in_busy && we_q && lane_sel;

  // Split the latched write word into lanes so the counter can pick one
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wlane
      assign wbyte_lane[gi] = wdata_q[8*gi +: 8];
    end
  endgenerate

  assign lane_wbyte = wbyte_lane[cnt_q];
  assign lane_rbyte = mem[lane_addr];

  // Assembly register after processing the current lane: only the lane
  // selected by the counter changes, and an unselected lane reads as zero.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_asm
      assign asm_busy[8*gi +: 8] =
        (cnt_q == 2'(gi)) ? (lane_sel ? lane_rbyte : 8'h00) : asm_q[8*gi +: 8];
    end
  endgenerate

  // Next-state logic: requests are sampled only in IDLE
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_addr_d = word_addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    we_d        = we_q;
    asm_d       = asm_q;
    rdata_d     = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (ram_ce_i) begin
          word_addr_d = ram_addr_i[ADDR_WIDTH-1:2];
          wdata_d     = ram_w_data_i;
          sel_d       = ram_sel_i;
          we_d        = ram_w_enable_i;
          cnt_d       = 2'd0;
          asm_d       = 32'h0;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!we_q) begin
          asm_d = asm_busy;
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = ST_DONE;
          // Publish the completed read word as DONE is entered
          if (!we_q) begin
            rdata_d = asm_busy;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset; reset aborts any access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      word_addr_q <= '0;
      wdata_q     <= 32'h0;
      sel_q       <= 4'h0;
      we_q        <= 1'b0;
      asm_q       <= 32'h0;
      rdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_addr_q <= word_addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      asm_q       <= asm_d;
      rdata_q     <= rdata_d;
    end
  end

  // Byte write port; state_q is forced to IDLE by reset, so no lane is
  // written once reset has been asserted.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[lane_addr] <= lane_wbyte;
    end
  end

  // Busy is raised combinationally in the request cycle so the CPU stalls
  // immediately; reset masks it so a request during reset never stalls.
  assign ram_busy_o   = !rst && (((state_q == ST_IDLE) && ram_ce_i) || in_busy);
  assign ram_done_o   = (state_q == ST_DONE);
  assign ram_r_data_o = rdata_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder: cycle-exact busy/done timing,
// byte lanes, address wrap, back-to-back requests and reset mid-access.
module tb_data_ram_responder;

  logic        clk;
  logic        rst;
  logic        ram_ce_i;
  logic        ram_w_enable_i;
  logic [3:0]  ram_sel_i;
  logic [31:0] ram_addr_i;
  logic [31:0] ram_w_data_i;
  logic [31:0] ram_r_data_o;
  logic        ram_busy_o;
  logic        ram_done_o;

  int n_cmp;
  int n_bad;

  data_ram_responder #(.ADDR_WIDTH(12)) dut (
    .clk            (clk),
    .rst            (rst),
    .ram_ce_i       (ram_ce_i),
    .ram_w_enable_i (ram_w_enable_i),
    .ram_sel_i      (ram_sel_i),
    .ram_addr_i     (ram_addr_i),
    .ram_w_data_i   (ram_w_data_i),
    .ram_r_data_o   (ram_r_data_o),
    .ram_busy_o     (ram_busy_o),
    .ram_done_o     (ram_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access starting at the current cycle (caller is just after a rising
  // edge). Inputs are scrambled during BUSY/DONE to show they are ignored.
  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wd,
                        input logic [31:0] exp_r);
    ram_ce_i       = 1'b1;
    ram_w_enable_i = we;
    ram_addr_i     = addr;
    ram_sel_i      = sel;
    ram_w_data_i   = wd;
    @(negedge clk);
    check({tag, " busy@T"}, 32'(ram_busy_o), 32'd1);
    check({tag, " done@T"}, 32'(ram_done_o), 32'd0);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      ram_ce_i       = 1'b1;
      ram_w_enable_i = 1'($urandom_range(0, 1));
      ram_addr_i     = $urandom;
      ram_sel_i      = 4'($urandom_range(0, 15));
      ram_w_data_i   = $urandom;
      @(negedge clk);
      if (c < 5) begin
        check($sformatf("%s busy@T+%0d", tag, c), 32'(ram_busy_o), 32'd1);
        check($sformatf("%s done@T+%0d", tag, c), 32'(ram_done_o), 32'd0);
      end else begin
        check({tag, " busy@T+5"}, 32'(ram_busy_o), 32'd0);
        check({tag, " done@T+5"}, 32'(ram_done_o), 32'd1);
        check({tag, " rdata"}, ram_r_data_o, exp_r);
      end
    end
    @(posedge clk);
    #1;
    ram_ce_i = 1'b0;
    @(negedge clk);
    check({tag, " busy@T+6"}, 32'(ram_busy_o), 32'd0);
    check({tag, " done@T+6"}, 32'(ram_done_o), 32'd0);
    $display("txn %s we=%0d addr=%h sel=%b wdata=%h -> rdata=%h", tag, we, addr, sel, wd, ram_r_data_o);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] b2b_busy;
    logic [11:0] b2b_done;
    n_cmp          = 0;
    n_bad          = 0;
    rst            = 1'b1;
    ram_ce_i       = 1'b1;
    ram_w_enable_i = 1'b0;
    ram_sel_i      = 4'hF;
    ram_addr_i     = 32'h0;
    ram_w_data_i   = 32'h0;

    // Reset state, with a request held during reset
    @(negedge clk);
    check("reset busy", 32'(ram_busy_o), 32'd0);
    check("reset done", 32'(ram_done_o), 32'd0);
    check("reset rdata", ram_r_data_o, 32'h0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    ram_ce_i = 1'b0;
    @(negedge clk);
    check("post-reset busy", 32'(ram_busy_o), 32'd0);
    @(posedge clk);
    #1;

    // Full word write then read; a write leaves rdata alone
    access("w10", 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h00000000);
    access("r10", 1'b0, 32'h10, 4'b1111, 32'h0,        32'hDEADBEEF);

    // Byte-lane writes and partial read
    access("w20a", 1'b1, 32'h20, 4'b1111, 32'h11223344, 32'hDEADBEEF);
    access("w20b", 1'b1, 32'h20, 4'b0100, 32'hAABBCCDD, 32'hDEADBEEF);
    access("r20",  1'b0, 32'h20, 4'b1111, 32'h0,        32'h11BB3344);
    access("r20p", 1'b0, 32'h20, 4'b0011, 32'h0,        32'h00003344);

    // Address wrap and ignored low bits
    access("w1003", 1'b1, 32'h1003,     4'b1111, 32'hCAFEF00D, 32'h00003344);
    access("r0000", 1'b0, 32'h0000,     4'b1111, 32'h0,        32'hCAFEF00D);
    access("rwrap", 1'b0, 32'hFFFFF000, 4'b1111, 32'h0,        32'hCAFEF00D);

    // Back-to-back reads with ce held high throughout
    b2b_busy = 12'b0111_1101_1111;
    b2b_done = 12'b1000_0010_0000;
    for (int c = 0; c < 12; c++) begin
      if (c == 0) begin
        ram_ce_i       = 1'b1;
        ram_w_enable_i = 1'b0;
        ram_sel_i      = 4'b1111;
        ram_addr_i     = 32'h10;
      end
      if (c == 6) begin
        ram_addr_i = 32'h20;
      end
      @(negedge clk);
      check($sformatf("b2b busy@T+%0d", c), 32'(ram_busy_o), 32'(b2b_busy[c]));
      check($sformatf("b2b done@T+%0d", c), 32'(ram_done_o), 32'(b2b_done[c]));
      if (c == 5)  check("b2b rdata1", ram_r_data_o, 32'hDEADBEEF);
      if (c == 11) check("b2b rdata2", ram_r_data_o, 32'h11BB3344);
      @(posedge clk);
      #1;
    end
    ram_ce_i = 1'b0;
    @(negedge clk);
    check("b2b idle busy", 32'(ram_busy_o), 32'd0);
    $display("txn b2b reads 0x10,0x20 -> rdata=%h", ram_r_data_o);
    @(posedge clk);
    #1;

    // Reset in the middle of a write, after lanes 0 and 1 are written
    access("w40z", 1'b1, 32'h40, 4'b1111, 32'h00000000, 32'h11BB3344);
    ram_ce_i       = 1'b1;
    ram_w_enable_i = 1'b1;
    ram_addr_i     = 32'h40;
    ram_sel_i      = 4'b1111;
    ram_w_data_i   = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    ram_ce_i = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst      = 1'b1;
    ram_ce_i = 1'b1;
    #1;
    check("rst-mid busy", 32'(ram_busy_o), 32'd0);
    check("rst-mid done", 32'(ram_done_o), 32'd0);
    check("rst-mid rdata", ram_r_data_o, 32'h0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    ram_ce_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst-drop busy%0d", c), 32'(ram_busy_o), 32'd0);
      check($sformatf("rst-drop done%0d", c), 32'(ram_done_o), 32'd0);
      @(posedge clk);
      #1;
    end
    $display("txn reset mid-write at 0x40");
    access("r40", 1'b0, 32'h40, 4'b1111, 32'h0, 32'h0000FFFF);

    // sel=0 accesses leave memory alone and read as zero
    access("w80",   1'b1, 32'h80, 4'b1111, 32'h55667788, 32'h0000FFFF);
    access("w80s0", 1'b1, 32'h80, 4'b0000, 32'h12345678, 32'h0000FFFF);
    access("r80",   1'b0, 32'h80, 4'b1111, 32'h0,        32'h55667788);
    access("r80s0", 1'b0, 32'h80, 4'b0000, 32'h0,        32'h00000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
